rv32i_fetch_queue: RTL and testbench
====================================

RV32I_FETCH_QUEUE -- requirements
Module: rv32i_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC and instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 32: instruction width.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries, a power of two and at least 2.
REQ-004 SHALL have parameter PC_INC, default 1: PC step per instruction (word-indexed instruction memory).
REQ-005 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-006 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-007 SHALL have port RN  input  1: reset, synchronous and active-low.
REQ-008 SHALL have port imem_req  output  1: fetch request issued this cycle.
REQ-009 SHALL have port imem_addr  output  ADDR_W: fetch address; always equals fetch_pc.
REQ-010 SHALL have port imem_rdata  input  INSTR_W: instruction data, valid exactly one cycle after imem_req.
REQ-011 SHALL have port redirect  input  1: branch/jump taken; flush the queue and refetch.
REQ-012 SHALL have port redirect_pc  input  ADDR_W: target PC when redirect=1.
REQ-013 SHALL have port dec_valid  output  1: head entry is available.
REQ-014 SHALL have port dec_ready  input  1: decode accepts the head entry.
REQ-015 SHALL have port dec_instr  output  INSTR_W: instruction at the queue head.
REQ-016 SHALL have port dec_pc  output  ADDR_W: PC of the head instruction.
REQ-017 SHALL have port NPC  output  ADDR_W: next PC to be delivered to decode.
REQ-018 SHALL have port fq_count  output  $clog2(DEPTH)+1: current queue occupancy.

Function
REQ-019 SHALL hold state as: fetch_pc; a DEPTH-entry circular queue of {instr, pc} with rd_ptr and wr_ptr wrapping at DEPTH; occupancy count; 1-bit outstanding flag.
REQ-020 SHALL drive imem_req = RN & ~redirect & (count + outstanding < DEPTH) combinationally; no pop credit is taken in the same cycle.
REQ-021 SHALL, when imem_req=1, set outstanding=1 and advance fetch_pc by PC_INC (modulo 2^ADDR_W) at the next edge; otherwise outstanding=0.
REQ-022 SHALL, in the cycle after a request, push {imem_rdata, pc of that request} at wr_ptr unless redirect=1 in that cycle.
REQ-023 SHALL give latency request -> dec_valid of 2 cycles: request in cycle N, push at end of N+1, dec_valid=1 in N+2.
REQ-024 SHALL drive dec_valid = (count != 0), with dec_instr and dec_pc taken from the head entry.
REQ-025 SHALL pop the head on dec_valid & dec_ready.
REQ-026 SHALL hold dec_instr and dec_pc stable while dec_valid=1 and dec_ready=0.
REQ-027 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-028 SHALL give redirect priority over everything: at the edge, count=0, rd_ptr=wr_ptr=0, outstanding=0, fetch_pc=redirect_pc.
REQ-029 SHALL, on redirect, drop any pop and any response arriving in that cycle; the first target request issues in the following cycle.
REQ-030 SHALL drive NPC = dec_pc when dec_valid=1, else fetch_pc.
REQ-031 SHALL never overflow (guaranteed by REQ-020).
REQ-032 SHALL give pop on empty no effect.
REQ-033 SHALL sustain 1 instruction/cycle with dec_ready held high when DEPTH >= 3.

Reset
REQ-034 SHALL, on any rising clk with RN=0, set: fetch_pc=RESET_PC, count=0, pointers=0, outstanding=0.
REQ-035 SHALL hold outputs during reset: imem_req=0, dec_valid=0, fq_count=0, NPC=RESET_PC, imem_addr=RESET_PC.
REQ-036 SHALL discard a response due in the first cycle after reset.
REQ-037 SHALL, when RN asserts mid-stream, abandon all queued and in-flight entries.
REQ-038 SHALL first request RESET_PC in the cycle after RN returns high.

Verification
REQ-039 SHALL pass reset: RN=0 for 2 cycles, then 1 -> imem_req=1 with imem_addr=0 in the first RN=1 cycle; dec_valid=1 with dec_pc=0 two cycles later.
REQ-040 SHALL pass streaming: dec_ready=1, memory returning addr+32'h00208300 -> dec_pc sequence 0,1,2,3,... on consecutive cycles with no bubbles after the first.
REQ-041 SHALL pass backpressure: DEPTH=4, dec_ready=0 -> fq_count rises to 4 and imem_req=0 while full; release -> entries 0..3 delivered in order, none lost or duplicated.
REQ-042 SHALL pass redirect mid-stream: redirect=1, redirect_pc=26 while 2 entries are queued and 1 is in flight -> fq_count=0 next cycle; next dec_pc is 26 and no stale PC appears.
REQ-043 SHALL pass redirect and pop together: dec_ready=1, redirect=1 with head pc=9 -> the pop is discarded, then dec_pc=49 after a redirect to 49.
REQ-044 SHALL pass wrap-around: with PC_INC=1, ADDR_W=8, start at 8'hFE -> dec_pc sequence FE, FF, 00, 01.

Source files
------------

// File: rtl/rv32i_fetch_queue.sv
// Instruction fetch queue: issues sequential imem reads, buffers {instr, pc} pairs in a
// circular queue and hands them to decode; a redirect flushes everything and refetches.
module rv32i_fetch_queue #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        INSTR_W  = 32,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  PC_INC   = ADDR_W'(1),
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       RN,
   output logic                       imem_req,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [INSTR_W-1:0]         imem_rdata,
   input  logic                       redirect,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic                       dec_valid,
   input  logic                       dec_ready,
   output logic [INSTR_W-1:0]         dec_instr,
   output logic [ADDR_W-1:0]          dec_pc,
   output logic [ADDR_W-1:0]          NPC,
   output logic [$clog2(DEPTH):0]     fq_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
   logic               outstanding_q, outstanding_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [INSTR_W-1:0] instr_d [DEPTH];
   logic [ADDR_W-1:0]  pc_q [DEPTH];
   logic [ADDR_W-1:0]  pc_d [DEPTH];

   logic [CW:0] credit_used;
   logic        push, pop;

   // Slots already promised to an in-flight response count against capacity.
   assign credit_used = {1'b0, count_q} + (CW + 1)'(outstanding_q);
   assign imem_req    = RN & ~redirect & (credit_used < DepthW);
   assign imem_addr   = fetch_pc_q;

   assign dec_valid = (count_q != '0);
   assign dec_instr = instr_q[rd_ptr_q];
   assign dec_pc    = pc_q[rd_ptr_q];
   assign NPC       = dec_valid ? dec_pc : fetch_pc_q;
   assign fq_count  = count_q;

   assign push = outstanding_q & ~redirect;
   assign pop  = dec_valid & dec_ready & ~redirect;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      req_pc_d      = req_pc_q;
      outstanding_d = 1'b0;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      instr_d       = instr_q;
      pc_d          = pc_q;

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            instr_d[wr_ptr_q] = imem_rdata;
            pc_d[wr_ptr_q]    = req_pc_q;
            wr_ptr_d          = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (imem_req) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_INC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!RN) begin
         fetch_pc_q    <= RESET_PC;
         req_pc_q      <= RESET_PC;
         outstanding_q <= 1'b0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         req_pc_q      <= req_pc_d;
         outstanding_q <= outstanding_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // Payload storage needs no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
   end

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Bench for rv32i_fetch_queue: directed vector table, randomized run against a queue-based
// reference model, and an 8-bit wrap-around instance.
module tb_rv32i_fetch_queue;

   localparam int unsigned AW    = 32;
   localparam int unsigned IW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] MAGIC = 32'h00208300;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rn, redirect, dec_ready;
   logic [AW-1:0] redirect_pc;
   logic [IW-1:0] imem_rdata;
   logic          imem_req, dec_valid;
   logic [AW-1:0] imem_addr, dec_pc, npc;
   logic [IW-1:0] dec_instr;
   logic [2:0]    fq_count;

   logic          w_rn = 1'b0;
   logic          w_redirect = 1'b0;
   logic          w_ready = 1'b1;
   logic [7:0]    w_rpc = 8'h00;
   logic [IW-1:0] w_rdata = '0;
   logic          w_req, w_valid;
   logic [7:0]    w_addr, w_pc, w_npc;
   logic [IW-1:0] w_instr;
   logic [2:0]    w_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic          resp_pend = 1'b0;
   logic [AW-1:0] resp_addr = '0;

   rv32i_fetch_queue #(
      .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .PC_INC(32'd1), .RESET_PC(32'h0)
   ) u_dut (
      .clk(clk), .RN(rn), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
      .dec_pc(dec_pc), .NPC(npc), .fq_count(fq_count)
   );

   rv32i_fetch_queue #(
      .ADDR_W(8), .INSTR_W(IW), .DEPTH(DEPTH), .PC_INC(8'd1), .RESET_PC(8'hFE)
   ) u_wrap (
      .clk(clk), .RN(w_rn), .imem_req(w_req), .imem_addr(w_addr),
      .imem_rdata(w_rdata), .redirect(w_redirect), .redirect_pc(w_rpc),
      .dec_valid(w_valid), .dec_ready(w_ready), .dec_instr(w_instr),
      .dec_pc(w_pc), .NPC(w_npc), .fq_count(w_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply inputs plus the memory response to last cycle's request, then settle.
   task automatic drive(input logic r, input logic red, input logic [31:0] rpc,
                        input logic rdy);
      rn          = r;
      redirect    = red;
      redirect_pc = rpc;
      dec_ready   = rdy;
      imem_rdata  = resp_pend ? resp_addr + MAGIC : $urandom;
      @(negedge clk);
   endtask

   task automatic advance();
      resp_pend = imem_req;
      resp_addr = imem_addr;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        chk;
      logic        rn;
      logic        red;
      logic [31:0] rpc;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] cnt;
   } vec_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   vec_t tv [28];
   ent_t m_q [$];
   logic [31:0] m_fetch, m_out_pc;
   logic        m_out;
   logic [7:0]  wexp [4];

   initial begin
      // chk rn red rpc rdy | req addr valid pc cnt
      tv[0]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0, 32'd0,  32'd0};
      tv[1]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  1'b0, 32'd0,  32'd0};
      tv[2]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0};
      tv[3]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd1,  1'b0, 32'd0,  32'd0};
      tv[4]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd2,  1'b1, 32'd0,  32'd1};
      tv[5]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd3,  1'b1, 32'd0,  32'd2};
      tv[6]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 32'd4,  1'b1, 32'd0,  32'd3};
      tv[7]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 32'd4,  1'b1, 32'd0,  32'd4};
      tv[8]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 32'd4,  1'b1, 32'd0,  32'd4};
      tv[9]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd4,  1'b1, 32'd1,  32'd3};
      tv[10] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd5,  1'b1, 32'd2,  32'd2};
      tv[11] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd6,  1'b1, 32'd3,  32'd2};
      tv[12] = '{1'b1, 1'b1, 1'b1, 32'd26, 1'b1, 1'b0, 32'd7,  1'b1, 32'd4,  32'd2};
      tv[13] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd26, 1'b0, 32'd0,  32'd0};
      tv[14] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd27, 1'b0, 32'd0,  32'd0};
      tv[15] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd28, 1'b1, 32'd26, 32'd1};
      tv[16] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd29, 1'b1, 32'd27, 32'd1};
      tv[17] = '{1'b1, 1'b1, 1'b1, 32'd9,  1'b1, 1'b0, 32'd30, 1'b1, 32'd28, 32'd1};
      tv[18] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd9,  1'b0, 32'd0,  32'd0};
      tv[19] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd10, 1'b0, 32'd0,  32'd0};
      tv[20] = '{1'b1, 1'b1, 1'b1, 32'd49, 1'b1, 1'b0, 32'd11, 1'b1, 32'd9,  32'd1};
      tv[21] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd49, 1'b0, 32'd0,  32'd0};
      tv[22] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd50, 1'b0, 32'd0,  32'd0};
      tv[23] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd51, 1'b1, 32'd49, 32'd1};
      tv[24] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0, 32'd0,  32'd0};
      tv[25] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0};
      tv[26] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd1,  1'b0, 32'd0,  32'd0};
      tv[27] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd2,  1'b1, 32'd0,  32'd1};

      // Directed table: reset, fill to full, drain, redirects, mid-stream reset.
      for (int i = 0; i < 28; i++) begin
         drive(tv[i].rn, tv[i].red, tv[i].rpc, tv[i].rdy);
         if (tv[i].chk) begin
            chk($sformatf("tv%0d_req", i), 32'(imem_req), 32'(tv[i].req));
            chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].addr);
            chk($sformatf("tv%0d_valid", i), 32'(dec_valid), 32'(tv[i].valid));
            chk($sformatf("tv%0d_count", i), 32'(fq_count), tv[i].cnt);
            if (tv[i].valid) begin
               chk($sformatf("tv%0d_pc", i), dec_pc, tv[i].pc);
               chk($sformatf("tv%0d_instr", i), dec_instr, tv[i].pc + MAGIC);
               chk($sformatf("tv%0d_npc", i), npc, tv[i].pc);
            end else begin
               chk($sformatf("tv%0d_npc", i), npc, tv[i].addr);
            end
         end
         advance();
      end

      // Randomized run against the reference model, started from a reset.
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      advance();
      m_q.delete();
      m_fetch  = 32'd0;
      m_out    = 1'b0;
      m_out_pc = 32'd0;
      for (int i = 0; i < 600; i++) begin
         logic        r, red, rdy, e_req, e_valid;
         logic [31:0] rpc;
         int          rdy_pct;
         rdy_pct = ((i / 60) % 3 == 0) ? 95 : (((i / 60) % 3 == 1) ? 50 : 10);
         r       = ($urandom_range(99) >= 2);
         red     = ($urandom_range(99) < 7);
         rpc     = $urandom;
         rdy     = ($urandom_range(99) < rdy_pct);
         drive(r, red, rpc, rdy);

         e_req   = r && !red && ((m_q.size() + int'(m_out)) < DEPTH);
         e_valid = (m_q.size() != 0);
         chk("rnd_req", 32'(imem_req), 32'(e_req));
         chk("rnd_addr", imem_addr, m_fetch);
         chk("rnd_valid", 32'(dec_valid), 32'(e_valid));
         chk("rnd_count", 32'(fq_count), 32'(m_q.size()));
         if (e_valid) begin
            chk("rnd_pc", dec_pc, m_q[0].pc);
            chk("rnd_instr", dec_instr, m_q[0].instr);
            chk("rnd_npc", npc, m_q[0].pc);
         end else begin
            chk("rnd_npc", npc, m_fetch);
         end

         if (!r) begin
            m_q.delete();
            m_fetch = 32'd0;
            m_out   = 1'b0;
         end else if (red) begin
            m_q.delete();
            m_fetch = rpc;
            m_out   = 1'b0;
         end else begin
            if (e_valid && rdy) void'(m_q.pop_front());
            if (m_out) m_q.push_back('{instr: m_out_pc + MAGIC, pc: m_out_pc});
            if (e_req) begin
               m_out_pc = m_fetch;
               m_fetch  = m_fetch + 32'd1;
               m_out    = 1'b1;
            end else begin
               m_out = 1'b0;
            end
         end
         advance();
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0);

      // 8-bit address wrap: FE, FF, 00, 01 back to back.
      wexp[0] = 8'hFE;
      wexp[1] = 8'hFF;
      wexp[2] = 8'h00;
      wexp[3] = 8'h01;
      begin
         int          got, first_cyc, last_cyc;
         logic        wpend;
         logic [7:0]  waddr;
         got       = 0;
         first_cyc = 0;
         last_cyc  = 0;
         w_rn = 1'b0;
         @(posedge clk); #1;
         @(posedge clk); #1;
         w_rn = 1'b1;
         @(negedge clk);
         chk("wrap_first_req", 32'(w_req), 32'd1);
         chk("wrap_first_addr", 32'(w_addr), 32'hFE);
         chk("wrap_first_count", 32'(w_count), 32'd0);
         for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (w_valid) begin
               if (got == 0) first_cyc = cyc;
               last_cyc = cyc;
               chk($sformatf("wrap_pc%0d", got), 32'(w_pc), 32'(wexp[got]));
               chk($sformatf("wrap_instr%0d", got), w_instr, 32'(w_pc) + MAGIC);
               chk($sformatf("wrap_npc%0d", got), 32'(w_npc), 32'(w_pc));
               got++;
            end
            wpend = w_req;
            waddr = w_addr;
            @(posedge clk); #1;
            w_rdata = wpend ? 32'(waddr) + MAGIC : $urandom;
            @(negedge clk);
         end
         chk("wrap_delivered", 32'(got), 32'd4);
         chk("wrap_no_bubble", 32'(last_cyc - first_cyc), 32'd3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
